// File: rtl/pc_seq_pkg.sv
// Shared next-PC select codes and priority resolution for
// the PC sequencer and its return-address stack.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_CALL,
    SEL_RET
  } sel_e;

  // Fixed priority: stall > ret > call > jump > branch > seq
  function automatic sel_e pick_sel(
    input logic stall,
    input logic ret,
    input logic call,
    input logic jump,
    input logic branch
  );
    sel_e s;
    s = SEL_SEQ;
    priority case (1'b1)
      stall:   s = SEL_HOLD;
      ret:     s = SEL_RET;
      call:    s = SEL_CALL;
      jump:    s = SEL_JUMP;
      branch:  s = SEL_BRANCH;
      default: s = SEL_SEQ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the fetch controller
// (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
  parameter int AW = 8
);
  logic          stall;
  logic          branch;
  logic [AW-1:0] branch_off;
  logic          jump;
  logic [AW-1:0] jump_addr;
  logic          call;
  logic          ret;
  logic [AW-1:0] pc;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_err;

  modport master (
    output stall, branch, branch_off,
    output jump, jump_addr, call, ret,
    input  pc, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, branch, branch_off,
    input  jump, jump_addr, call, ret,
    output pc, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack: LIFO with registered empty/full
// flags; pushes when full and pops when empty are dropped.
module pc_ras #(
  parameter  int AW        = 8,
  parameter  int RAS_DEPTH = 4,
  localparam int PW        = $clog2(RAS_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [AW-1:0] mem_q [RAS_DEPTH];
  logic [AW-1:0] mem_d [RAS_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] top;
  logic          empty_q, empty_d;
  logic          full_q, full_d;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push && !full_q) begin
      mem_d[cnt_q[PW-1:0]] = din;
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !empty_q) begin
      cnt_d = cnt_q - 1'b1;
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CW'(RAS_DEPTH));
    top     = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Only the count is reset; stale entries are unreachable
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[top[PW-1:0]];
  assign empty = empty_q;
  assign full  = full_q;
  assign count = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with relative branch, absolute jump and
// call/return through a small return-address stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int            AW        = 8,
  parameter int            RAS_DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC  = '0
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] ras_top;
  logic [CW-1:0] ras_cnt;
  logic          err_q, err_d;
  logic          push, pop;
  logic          empty, full, at_cap;
  sel_e          sel;

  pc_ras #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ras_top),
    .empty (empty),
    .full  (full),
    .count (ras_cnt)
  );

  always_comb begin
    sel    = pick_sel(bus.stall, bus.ret, bus.call,
                      bus.jump, bus.branch);
    pc_inc = pc_q + 1'b1;
    at_cap = (ras_cnt == CW'(RAS_DEPTH));
    push   = (sel == SEL_CALL) && !at_cap;
    pop    = (sel == SEL_RET) && !empty;
    pc_d   = pc_q;
    err_d  = err_q;
    unique case (sel)
      SEL_HOLD: pc_d = pc_q;
      SEL_RET: begin
        pc_d = empty ? pc_inc : ras_top;
        if (empty) err_d = 1'b1;
      end
      SEL_CALL: begin
        pc_d = bus.jump_addr;
        if (at_cap) err_d = 1'b1;
      end
      SEL_JUMP:   pc_d = bus.jump_addr;
      SEL_BRANCH: pc_d = pc_q + bus.branch_off;
      default:    pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: queue-based model checked every
// cycle, plus literal expectations on key sequences.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;
  bit   model_ok = 1'b0;
  int   m_pc = 0;
  bit   m_err = 1'b0;
  int   q[$];

  pc_sequencer_if #(.AW(8)) bus ();

  pc_sequencer #(
    .AW        (8),
    .RAS_DEPTH (4),
    .RESET_PC  (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Model: pc as an integer, stack as a queue
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 0;
      q.delete();
      m_err = 1'b0;
      model_ok = 1'b1;
    end else if (bus.stall) begin
    end else if (bus.ret) begin
      if (q.size() > 0) m_pc = q.pop_back();
      else begin
        m_pc = (m_pc + 1) % 256;
        m_err = 1'b1;
      end
    end else if (bus.call) begin
      if (q.size() < 4) q.push_back((m_pc + 1) % 256);
      else m_err = 1'b1;
      m_pc = int'(bus.jump_addr);
    end else if (bus.jump) begin
      m_pc = int'(bus.jump_addr);
    end else if (bus.branch) begin
      m_pc = (m_pc + int'(bus.branch_off)) % 256;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_pc", 32'(bus.pc), 32'(m_pc));
      chk("model_empty", 32'(bus.ras_empty),
          32'(q.size() == 0));
      chk("model_full", 32'(bus.ras_full),
          32'(q.size() == 4));
      chk("model_err", 32'(bus.ras_err), 32'(m_err));
    end
  end

  task automatic drive(input bit st, input bit rt,
                       input bit cl, input bit jp,
                       input logic [7:0] ja,
                       input bit br,
                       input logic [7:0] off,
                       input bit rn);
    bus.stall      = st;
    bus.ret        = rt;
    bus.call       = cl;
    bus.jump       = jp;
    bus.jump_addr  = ja;
    bus.branch     = br;
    bus.branch_off = off;
    rst_n          = rn;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 8'h00, 0, 8'h00, 1);
  endtask
  task automatic do_jump(input logic [7:0] a);
    drive(0, 0, 0, 1, a, 0, 8'h00, 1);
  endtask
  task automatic do_call(input logic [7:0] a);
    drive(0, 0, 1, 0, a, 0, 8'h00, 1);
  endtask
  task automatic do_ret();
    drive(0, 1, 0, 0, 8'h00, 0, 8'h00, 1);
  endtask
  task automatic do_rst();
    drive(0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic lit(input string name,
                     input logic [7:0] pc,
                     input bit e, input bit f,
                     input bit er);
    chk({name, "_pc"}, 32'(bus.pc), 32'(pc));
    chk({name, "_empty"}, 32'(bus.ras_empty), 32'(e));
    chk({name, "_full"}, 32'(bus.ras_full), 32'(f));
    chk({name, "_err"}, 32'(bus.ras_err), 32'(er));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall = 0; bus.ret = 0; bus.call = 0;
    bus.jump = 0; bus.branch = 0;
    bus.jump_addr = '0; bus.branch_off = '0;
    @(negedge clk);
    lit("reset", 8'h00, 1, 0, 0);
    idle(); lit("idle1", 8'h01, 1, 0, 0);
    idle(); lit("idle2", 8'h02, 1, 0, 0);
    idle(); lit("idle3", 8'h03, 1, 0, 0);

    do_jump(8'h10); lit("jmp10", 8'h10, 1, 0, 0);
    drive(0, 0, 0, 0, 8'h00, 1, 8'hF8, 1);
    lit("br_neg", 8'h08, 1, 0, 0);
    drive(0, 0, 0, 0, 8'h00, 1, 8'h0C, 1);
    lit("br_pos", 8'h14, 1, 0, 0);
    do_jump(8'hFF); lit("jmpff", 8'hFF, 1, 0, 0);
    idle(); lit("wrap", 8'h00, 1, 0, 0);

    do_jump(8'h20);
    do_call(8'h80); lit("call80", 8'h80, 0, 0, 0);
    idle(); lit("sub1", 8'h81, 0, 0, 0);
    idle(); lit("sub2", 8'h82, 0, 0, 0);
    do_ret(); lit("ret21", 8'h21, 1, 0, 0);

    do_call(8'h10); lit("nest1", 8'h10, 0, 0, 0);
    do_call(8'h20); lit("nest2", 8'h20, 0, 0, 0);
    do_call(8'h30); lit("nest3", 8'h30, 0, 0, 0);
    do_call(8'h50); lit("nest4", 8'h50, 0, 1, 0);
    do_call(8'h40); lit("ovf", 8'h40, 0, 1, 1);
    do_ret(); lit("pop1", 8'h31, 0, 0, 1);
    do_ret(); lit("pop2", 8'h21, 0, 0, 1);
    do_ret(); lit("pop3", 8'h11, 0, 0, 1);
    do_ret(); lit("pop4", 8'h22, 1, 0, 1);

    do_rst(); lit("rst2", 8'h00, 1, 0, 0);
    do_jump(8'h05);
    do_ret(); lit("udf", 8'h06, 1, 0, 1);
    drive(1, 1, 0, 1, 8'h99, 0, 8'h00, 1);
    lit("stall", 8'h06, 1, 0, 1);

    do_rst();
    do_jump(8'h32);
    do_call(8'h70); lit("call70", 8'h70, 0, 0, 0);
    drive(1, 0, 1, 0, 8'h99, 0, 8'h00, 1);
    lit("stall_call", 8'h70, 0, 0, 0);
    drive(0, 1, 1, 1, 8'h90, 1, 8'h05, 1);
    lit("all4", 8'h33, 1, 0, 0);
    do_ret(); lit("udf2", 8'h34, 1, 0, 1);
    do_call(8'h60); lit("call60", 8'h60, 0, 0, 1);
    drive(1, 0, 1, 0, 8'h44, 0, 8'h00, 0);
    lit("rst_call", 8'h00, 1, 0, 0);
    idle(); lit("post_rst", 8'h01, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter AW, default 8, PC/address width in bits (AW >= 4).
REQ-002 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >= 2).
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port stall  input  1  hold PC and stack; ignore all control inputs this cycle.
REQ-007 SHALL have port branch  input  1  taken relative branch.
REQ-008 SHALL have port branch_off  input  AW  two's-complement branch offset.
REQ-009 SHALL have port jump  input  1  absolute jump.
REQ-010 SHALL have port jump_addr  input  AW  absolute target for jump and call.
REQ-011 SHALL have port call  input  1  push return address, go to jump_addr.
REQ-012 SHALL have port ret  input  1  pop return address into PC.
REQ-013 SHALL have port pc  output  AW  current program counter (registered).
REQ-014 SHALL have port ras_empty  output  1  stack holds 0 entries.
REQ-015 SHALL have port ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-016 SHALL have port ras_err  output  1  sticky stack overflow/underflow flag.

Function
REQ-017 SHALL sample controls on each rising clk edge; the selected next PC appears on pc one cycle later (latency 1, no combinational path from inputs to pc).
REQ-018 SHALL resolve concurrent controls by fixed priority: stall > ret > call > jump > branch > sequential.
REQ-019 Sequential: pc <= pc + 1, modulo 2^AW (wrap from all-ones to 0, no flag).
REQ-020 Branch: pc <= pc + branch_off, modulo 2^AW; a negative offset wraps below 0.
REQ-021 Jump: pc <= jump_addr; stack unchanged.
REQ-022 Call, stack not full: push (pc + 1) mod 2^AW; pc <= jump_addr.
REQ-023 Call, stack full: pc <= jump_addr; push discarded; existing entries unchanged; ras_err set.
REQ-024 Ret, stack not empty: pc <= top entry; entry popped.
REQ-025 Ret, stack empty: pc <= pc + 1; ras_err set; stack stays empty.
REQ-026 Ret and call asserted together: ret only; call ignored, no push.
REQ-027 Stall: pc, stack contents, stack pointer and ras_err hold, regardless of other inputs.
REQ-028 ras_empty/ras_full SHALL be registered functions of the stack count, valid the cycle after the push/pop.
REQ-029 ras_err SHALL remain 1 until reset once set.

Reset
REQ-030 With rst_n = 0 at a rising edge: pc <= RESET_PC, stack count <= 0, ras_empty <= 1, ras_full <= 0, ras_err <= 0.
REQ-031 Reset SHALL take priority over stall and all controls, including mid-call/ret sequences; stack contents need not be cleared, only the count.

Structure
REQ-032 Next-PC select codes (SEQ, BRANCH, JUMP, CALL, RET) and the priority order SHALL be defined as constants in shared package pc_seq_pkg.
REQ-033 Return-address stack SHALL be sub-module pc_ras (push, pop, data in/out, empty, full, count; parameters AW, RAS_DEPTH); all other logic in pc_sequencer.

Verification
REQ-034 Reset then 3 idle cycles, AW=8, RESET_PC=0 -> pc = 0,1,2,3; ras_empty=1, ras_err=0.
REQ-035 pc=0x10, branch with branch_off=0xF8 (-8) -> pc=0x08 next cycle; pc=0xFF idle -> pc=0x00.
REQ-036 pc=0x20, call jump_addr=0x80; 2 idle; ret -> pc 0x80,0x81,0x82,0x21; ras_empty 0 then 1.
REQ-037 Four nested calls (RAS_DEPTH=4) -> ras_full=1; fifth call to 0x40 -> pc=0x40, ras_err=1; four rets return in LIFO order.
REQ-038 Empty stack, pc=0x05, ret -> pc=0x06, ras_err=1; stall with jump=1, ret=1 -> pc holds 0x06, stack unchanged.
REQ-039 jump+branch+call+ret in one cycle with 1 entry (0x33) -> pc=0x33, no push; rst_n=0 while call asserted -> pc=RESET_PC, ras_empty=1, ras_err=0.
